// File: rtl/shift_sequencer.sv
// shift_sequencer
//
// Multi-cycle barrel-shift controller wrapped around a purely combinational
// single-step shifter. The shifter supports only LSR1, LSL1, LSL16 and ASR1.
// This block builds arbitrary 0..31-bit shifts by replaying those steps on an
// internal accumulator, one step per clock.
//
// Handshake: start is a request pulse. It is accepted on a rising edge only
// when the block is in IDLE or DONE, and it is ignored in SHIFT. busy is high
// while shifting. done pulses high for exactly one cycle, and result is valid
// in that cycle. result holds its value until the next accepted operation
// completes.
//
// Ports:
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   start           : request pulse; op/amount/data_in are sampled with it
//   op              : 00 LSR, 01 LSL, 10 ASR, 11 reserved (pass-through)
//   amount          : unsigned shift distance
//   data_in         : operand
//   sh_in, sh       : drive the shifter data input and its 3-bit control code
//   sh_data         : shifter output; combinational from sh_in/sh in the same cycle
//   busy, done      : SHIFT-state flag and one-cycle completion pulse
//   result          : registered final value
//   state_dbg       : current FSM state (00 IDLE, 01 SHIFT, 10 DONE)

module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] sh_in,
  output logic [2:0]       sh,
  input  logic [WIDTH-1:0] sh_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  localparam logic [1:0] OP_LSR  = 2'b00;
  localparam logic [1:0] OP_LSL  = 2'b01;
  localparam logic [1:0] OP_ASR  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [2:0] SH_NONE  = 3'b000;
  localparam logic [2:0] SH_LSR1  = 3'b001;
  localparam logic [2:0] SH_LSL1  = 3'b010;
  localparam logic [2:0] SH_LSL16 = 3'b011;
  localparam logic [2:0] SH_ASR1  = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_16   = CNT_W'(16);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;

  logic             accept;
  logic             zero_len;
  logic [2:0]       sh_sel;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] cnt_next;

  assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
  assign zero_len  = (amount == CNT_ZERO) || (op == OP_PASS);
  assign sh_in     = acc;
  assign sh        = sh_sel;
  assign busy      = (state == S_SHIFT);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  // Pick the shifter step for this cycle and how much distance it covers.
  // A 16-bit left step is used only while at least 16 bits remain, so the
  // counter can never wrap.
  always_comb begin
    sh_sel = SH_NONE;
    step   = CNT_ZERO;
    if (state == S_SHIFT) begin
      case (op_q)
        OP_LSR: begin
          sh_sel = SH_LSR1;
          step   = CNT_ONE;
        end
        OP_ASR: begin
          sh_sel = SH_ASR1;
          step   = CNT_ONE;
        end
        OP_LSL: begin
          if (cnt >= CNT_16) begin
            sh_sel = SH_LSL16;
            step   = CNT_16;
          end else begin
            sh_sel = SH_LSL1;
            step   = CNT_ONE;
          end
        end
        default: begin
          // The pass-through op never enters SHIFT. If it ever does, drain
          // the counter so the FSM exits on the next edge.
          sh_sel = SH_NONE;
          step   = cnt;
        end
      endcase
    end
  end

  assign cnt_next = cnt - step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= OP_LSR;
      result <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            acc  <= data_in;
            cnt  <= amount;
            op_q <= op;
            if (zero_len) begin
              // Zero-length work completes immediately with the operand itself.
              state  <= S_DONE;
              result <= data_in;
            end else begin
              state <= S_SHIFT;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          acc <= sh_data;
          cnt <= cnt_next;
          if (cnt_next == CNT_ZERO) begin
            state  <= S_DONE;
            result <= sh_data;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  amount = 5'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] sh_in;
  logic [2:0]  sh;
  logic [31:0] sh_data;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amount(amount),
    .data_in(data_in), .sh_in(sh_in), .sh(sh), .sh_data(sh_data),
    .busy(busy), .done(done), .result(result), .state_dbg(state_dbg)
  );

  // Combinational single-step shifter.
  always_comb begin
    case (sh)
      3'b001:  sh_data = sh_in >> 1;
      3'b010:  sh_data = sh_in << 1;
      3'b011:  sh_data = sh_in << 16;
      3'b101:  sh_data = $unsigned($signed(sh_in) >>> 1);
      default: sh_data = sh_in;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [4:0] a, input logic [31:0] d);
    case (o)
      2'b00:   return d >> a;
      2'b01:   return d << a;
      2'b10:   return $unsigned($signed(d) >>> a);
      default: return d;
    endcase
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [4:0] a);
    if (o == 2'b11 || a == 5'd0) return 0;
    if (o == 2'b01) return (a >= 5'd16 ? 1 : 0) + int'(a % 5'd16);
    return int'(a);
  endfunction

  // Every done pulse must match the oldest outstanding request, both in value
  // and in the cycle it appears.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("result", result, exp_q.pop_front());
        check("done_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the next negedge with start dropped.
  task automatic issue(input logic [1:0] o, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] exp_res);
    start = 1'b1; op = o; amount = a; data_in = d;
    exp_q.push_back(exp_res);
    exp_cyc_q.push_back(cyc + 1 + latency(o, a));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  amount;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];
  logic [2:0] lsl20_sh[5];

  initial begin
    vecs[0]  = '{2'b00, 5'd4,  32'h8000_0000, 32'h0800_0000};
    vecs[1]  = '{2'b10, 5'd4,  32'h8000_0010, 32'hF800_0001};
    vecs[2]  = '{2'b01, 5'd20, 32'h0000_0001, 32'h0010_0000};
    vecs[3]  = '{2'b01, 5'd31, 32'h0000_0001, 32'h8000_0000};
    vecs[4]  = '{2'b00, 5'd0,  32'h1234_5678, 32'h1234_5678};
    vecs[5]  = '{2'b11, 5'd9,  32'h1234_5678, 32'h1234_5678};
    vecs[6]  = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[7]  = '{2'b01, 5'd16, 32'h0000_ABCD, 32'hABCD_0000};
    vecs[8]  = '{2'b00, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[9]  = '{2'b10, 5'd5,  32'h7FFF_FFFF, 32'h03FF_FFFF};
    vecs[10] = '{2'b01, 5'd15, 32'h0000_0003, 32'h0001_8000};
    lsl20_sh = '{3'b011, 3'b010, 3'b010, 3'b010, 3'b010};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sh", 32'(sh), 32'd0);
    check("rst_sh_in", sh_in, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].amount, vecs[i].data, vecs[i].exp);
      if (latency(vecs[i].op, vecs[i].amount) == 0) begin
        check("zero_len_sh", 32'(sh), 32'd0);
        check("zero_len_busy", 32'(busy), 32'd0);
      end
      wait_drain();
    end

    // LSR 4: sh=001 on each of the 4 busy cycles, then idle code
    issue(2'b00, 5'd4, 32'h8000_0000, 32'h0800_0000);
    for (int i = 0; i < 4; i++) begin
      check("lsr_busy", 32'(busy), 32'd1);
      check("lsr_sh", 32'(sh), 32'b001);
      @(negedge clk);
    end
    check("lsr_busy_end", 32'(busy), 32'd0);
    check("lsr_sh_end", 32'(sh), 32'd0);
    wait_drain();

    // ASR 4: accumulator walk visible on sh_in
    issue(2'b10, 5'd4, 32'h8000_0010, 32'hF800_0001);
    check("asr_acc0", sh_in, 32'h8000_0010);
    @(negedge clk); check("asr_acc1", sh_in, 32'hC000_0008);
    @(negedge clk); check("asr_acc2", sh_in, 32'hE000_0004);
    @(negedge clk); check("asr_acc3", sh_in, 32'hF000_0002);
    wait_drain();

    // LSL 20: one 16-step then four 1-steps
    issue(2'b01, 5'd20, 32'h0000_0001, 32'h0010_0000);
    for (int i = 0; i < 5; i++) begin
      check("lsl20_busy", 32'(busy), 32'd1);
      check("lsl20_sh", 32'(sh), 32'(lsl20_sh[i]));
      @(negedge clk);
    end
    check("lsl20_busy_end", 32'(busy), 32'd0);
    wait_drain();

    // start while busy is ignored
    issue(2'b00, 5'd8, 32'hF000_0000, 32'h00F0_0000);
    @(negedge clk);
    start = 1'b1; op = 2'b01; amount = 5'd3; data_in = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    check("ignore_busy", 32'(busy), 32'd1);
    wait_drain();

    // Back-to-back: new start during the DONE cycle
    issue(2'b00, 5'd2, 32'h0000_0100, 32'h0000_0040);
    begin
      int t = 0;
      while (!done && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("b2b_done_seen", 32'(done), 32'd1);
    end
    issue(2'b10, 5'd3, 32'h8000_0000, 32'hF000_0000);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_drain();

    // Reset mid-operation
    issue(2'b00, 5'd10, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sh", 32'(sh), 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 5'd4, 32'h0000_0010, 32'h0000_0001);
    wait_drain();

    // Random operations against the direct-shift model
    for (int i = 0; i < 20; i++) begin
      logic [1:0]  ro;
      logic [4:0]  ra;
      logic [31:0] rd;
      ro = 2'($urandom_range(0, 3));
      ra = 5'($urandom_range(0, 31));
      rd = $urandom;
      issue(ro, ra, rd, model(ro, ra, rd));
      wait_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name:
shift_sequencer

Overview:
- Multi-cycle barrel-shift controller that sits directly around the datapath shifter. It drives the shifter's data input and 3-bit control code, and consumes the shifter's output every cycle.
- Turns the shifter's single-step operations (LSR1, LSL1, LSL16, ASR1) into arbitrary 0–31-bit shifts.
- Holds the running operand in an internal accumulator and presents a registered result with a one-cycle done pulse.
- Used by the execute stage for shift-by-N instructions.

Parameters:
- WIDTH, 32, data width. Must match the shifter bus width; only 32 is supported.
- CNT_W, 5, shift-amount width (max amount 2^CNT_W-1 = 31).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse. Sampled only when the block can accept (state IDLE or DONE).
- op  in  2  operation: 00 LSR, 01 LSL, 10 ASR, 11 reserved (pass-through).
- amount  in  CNT_W  shift distance, unsigned.
- data_in  in  WIDTH  operand, sampled with start.
- sh_in  out  WIDTH  to shifter data input. Always equals accumulator (combinational).
- sh  out  3  to shifter control lines.
- sh_data  in  WIDTH  from shifter output bus.
- busy  out  1  high while state is SHIFT.
- done  out  1  one-cycle pulse when result becomes valid.
- result  out  WIDTH  registered final value. Held until the next accepted start completes.

Behaviour:
- Single clock domain: clk. Reset is asynchronous, active-low (rst_n). All state flops clear immediately on rst_n=0.
- Reset values:
  - state=IDLE, acc=0, cnt=0, op_q=00.
  - result=0, busy=0, done=0.
  - sh=000 (the shifter's "no shift" code); sh_in=0.
- States and transitions:
  - IDLE: sh=000. On start=1, load acc<=data_in, cnt<=amount, op_q<=op.
    - Go to DONE if amount==0 or op==11.
    - Otherwise go to SHIFT.
  - SHIFT: busy=1. Each cycle, select sh from op_q and cnt:
    - LSR → 001, cnt-=1.
    - ASR → 101, cnt-=1.
    - LSL with cnt>=16 → 011, cnt-=16.
    - LSL with cnt<16 → 010, cnt-=1.
    - Then acc<=sh_data. When the post-update cnt==0, go to DONE; otherwise stay in SHIFT.
  - DONE: done=1 for exactly this cycle. result was loaded from acc on the transition into DONE; sh=000.
    - start=1 here is accepted exactly as in IDLE, allowing back-to-back operation.
    - Otherwise go to IDLE.
- Latency, counting N as the number of SHIFT cycles:
  - LSR and ASR: N = amount.
  - LSL: N = (amount>=16 ? 1 : 0) + (amount mod 16). Maximum N is 16 (amount 31).
  - Start accepted on edge E0; busy is high for edges E1..EN; done is high in the cycle after edge EN.
  - amount==0 or op==11: done is high in the cycle after E0, with result=data_in and no shifter activity.
- Inputs are ignored while busy: start, op, amount and data_in have no effect in SHIFT.
- Interface timing: sh_data is treated as combinational from sh_in and sh within the same cycle (the shifter is purely combinational). No registered stage exists between the two blocks.
- op=11 is reserved: it completes as a zero-length operation.
- result changes only on entry to DONE. It is never partially updated.
- Reset mid-operation: everything returns to reset values asynchronously, any in-flight operation is abandoned, and done is not asserted. The first start after rst_n deasserts behaves normally.
- Counter arithmetic: cnt is unsigned CNT_W bits and never underflows. The LSL 16-step is chosen only when cnt>=16.

Test Plan:
- Bench setup: a combinational shifter model is connected to sh_in, sh and sh_data.
- LSR: op=00, amount=4, data_in=0x80000000 → busy for 4 cycles with sh=001 each cycle; done in the 5th cycle after start; result=0x08000000.
- ASR: op=10, amount=4, data_in=0x80000010 → intermediate acc values 0xC0000008, 0xE0000004, 0xF0000002; result=0xF8000001.
- LSL: op=01, amount=20, data_in=0x00000001 → sh sequence 011,010,010,010,010 (5 busy cycles); result=0x00100000. Also amount=31 → 16 busy cycles, result=0x80000000.
- Zero-length: amount=0 with data_in=0x12345678, and separately op=11 with amount=9 → sh stays 000 throughout; done the cycle after start; result=0x12345678.
- Start during SHIFT: start pulsed with different data while busy → ignored; original result delivered.
- Back-to-back: start asserted during the DONE cycle → new op accepted and completes.
- Reset mid-operation: rst_n pulsed low during SHIFT → result=0, done=0, sh=000 immediately; the subsequent LSR of 0x00000010 by 4 gives 0x00000001.
